bitmap_dump: RTL and testbench

- Readback engine for the 128x128 3-bit video RAM that the bitmap generator writes.
- Owns that RAM's read port (or a third port / arbitrated port) when a dump is requested.
- Scans addresses linearly, {y[6:0], x[6:0]}, from 0 to LAST_ADDR.
- Streams each pixel colour out over a valid/ready interface, e.g. toward a UART transmitter or a checker.

---
 rtl/bitmap_dump_if.sv | 13 +
 rtl/bitmap_dump.sv | 158 +++++++++++++++
 tb/tb_bitmap_dump.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitmap_dump_if.sv
// Pixel stream from the bitmap readback engine: valid/ready with a last-beat marker.
// The master drives data, valid and last. The slave drives ready.
interface bitmap_dump_if #(
    parameter int DATA_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] px_data;
    logic                  px_valid;
    logic                  px_ready;
    logic                  px_last;

    modport master (output px_data, px_valid, px_last, input  px_ready);
    modport slave  (input  px_data, px_valid, px_last, output px_ready);
endinterface

// File: rtl/bitmap_dump.sv
// Video RAM readback: linear scan 0..LAST_ADDR streamed out; first beat valid 2 cycles after start, 1 beat/clk.
// Back-pressure via 2-credit read issue into a 2-entry FIFO; DUMP_CSUM_EN appends an XOR checksum beat.
module bitmap_dump #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 3,
    parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    bitmap_dump_if.master         px,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST_ADDR);

`ifdef DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, CSUM, DONE} state_t;
    localparam logic PIX_LAST = 1'b0;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic PIX_LAST = 1'b1;
`endif

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                inflight;
    logic                inflight_last;
    logic [DATA_WIDTH:0] fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;

    logic                fifo_vld;
    logic                pop;
    logic                issue;
    logic                last_issue;
    logic [2:0]          occ;
    logic [DATA_WIDTH:0] head;

    // Occupancy counts buffered entries plus the read in flight, net of this cycle's pop.
    always_comb begin
        head       = fifo_mem[rd_ptr];
        fifo_vld   = (fifo_cnt != 2'd0);
        pop        = fifo_vld & px.px_ready;
        occ        = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        last_issue = (cnt == LAST_CNT);
        issue      = (state == RUN) && (occ < 3'd2);
    end

`ifdef DUMP_CSUM_EN
    logic [DATA_WIDTH-1:0] acc;
    logic                  csum_beat;

    assign csum_beat   = (state == CSUM);
    assign px.px_valid = fifo_vld | csum_beat;
    assign px.px_data  = csum_beat ? acc : (fifo_vld ? head[DATA_WIDTH-1:0] : '0);
    assign px.px_last  = csum_beat | (fifo_vld & head[DATA_WIDTH]);
`else
    assign px.px_valid = fifo_vld;
    assign px.px_data  = fifo_vld ? head[DATA_WIDTH-1:0] : '0;
    assign px.px_last  = fifo_vld & head[DATA_WIDTH];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            ram_addr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_mem[0]   <= '0;
            fifo_mem[1]   <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_cnt      <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef DUMP_CSUM_EN
            acc           <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (issue) begin
                ram_addr      <= cnt[ADDR_WIDTH-1:0];
                cnt           <= cnt + 1'b1;
                inflight_last <= PIX_LAST & last_issue;
            end
            inflight <= issue;

            // RAM data for the previous cycle's read lands in the FIFO.
            if (inflight) begin
                fifo_mem[wr_ptr] <= {inflight_last, ram_dout};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};

`ifdef DUMP_CSUM_EN
            if (pop) begin
                acc <= acc ^ head[DATA_WIDTH-1:0];
            end
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
`ifdef DUMP_CSUM_EN
                        acc   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (issue && last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((fifo_cnt == 2'd0) && !inflight) begin
`ifdef DUMP_CSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef DUMP_CSUM_EN
                CSUM: begin
                    if (px.px_ready) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_dump.sv
// Randomized bench for bitmap_dump: a full-size engine and a 16-pixel engine share one RAM model,
// and every received beat is compared against the address-ordered pixel list.
module tb_bitmap_dump;
    localparam int AW     = 14;
    localparam int DW     = 3;
    localparam int LAST_B = 16383;
    localparam int LAST_S = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_b = 1'b0;
    logic          start_s = 1'b0;
    logic [AW-1:0] ram_addr_b, ram_addr_s;
    logic [DW-1:0] ram_dout_b, ram_dout_s;
    logic          busy_b, done_b, busy_s, done_s;
    logic [DW-1:0] ram [0:LAST_B];

    bitmap_dump_if #(.DATA_WIDTH(DW)) px_b ();
    bitmap_dump_if #(.DATA_WIDTH(DW)) px_s ();

    // Registered address, data valid in the following cycle.
    assign ram_dout_b = ram[ram_addr_b];
    assign ram_dout_s = ram[ram_addr_s];

    bitmap_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ram_addr(ram_addr_b),
        .ram_dout(ram_dout_b), .px(px_b), .busy(busy_b), .done(done_b));

    bitmap_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST_S)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .ram_addr(ram_addr_s),
        .ram_dout(ram_dout_s), .px(px_s), .busy(busy_s), .done(done_s));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_d [$];
    bit            exp_l [$];
    int beats, bad, unstable, occ_bad, fv_cyc, fv_data, fx_cyc, lx_cyc;
    int done_cnt, busy_low, stall_addr, t0;
    int done_cyc [2];
    bit hit;

    function automatic int nbeats(input int last);
`ifdef DUMP_CSUM_EN
        return last + 2;
`else
        return last + 1;
`endif
    endfunction

    // Expected stream: pixels in address order, then the XOR beat when checksums are on.
    function automatic void build(input int last, input int ndumps);
        logic [DW-1:0] x;
        exp_d.delete();
        exp_l.delete();
        for (int k = 0; k < ndumps; k++) begin
            x = '0;
            for (int i = 0; i <= last; i++) begin
                exp_d.push_back(ram[i]);
                x = x ^ ram[i];
`ifdef DUMP_CSUM_EN
                exp_l.push_back(1'b0);
`else
                exp_l.push_back(i == last);
`endif
            end
`ifdef DUMP_CSUM_EN
            exp_d.push_back(x);
            exp_l.push_back(1'b1);
`endif
        end
    endfunction

    // mode: 0 ready high, 1 random, 2 stall 100 cycles after first valid, 3 toggle
    task automatic run(input bit s, input int mode, input int ndumps, input int abort_at);
        int            last, budget, addr;
        bit            v, l, b, dn, r, pst, pl;
        logic [DW-1:0] d, pd;
        last = s ? LAST_S : LAST_B;
        build(last, ndumps);
        beats = 0; bad = 0; unstable = 0; occ_bad = 0; done_cnt = 0; busy_low = 0;
        fv_cyc = -1; fv_data = -1; fx_cyc = -1; lx_cyc = -1; stall_addr = -1;
        done_cyc[0] = -1; done_cyc[1] = -1; hit = 1'b0;
        pst = 1'b0; pl = 1'b0; pd = '0;
        budget = 4 * nbeats(last) * ndumps + 300;
        @(posedge clk); #1;
        if (s) start_s = 1'b1; else start_b = 1'b1;
        t0 = cyc + 1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            v    = s ? px_s.px_valid : px_b.px_valid;
            d    = s ? px_s.px_data  : px_b.px_data;
            l    = s ? px_s.px_last  : px_b.px_last;
            b    = s ? busy_s : busy_b;
            dn   = s ? done_s : done_b;
            addr = s ? int'(ram_addr_s) : int'(ram_addr_b);
            if (b && done_cnt == ndumps - 1) begin
                if (s) start_s = 1'b0; else start_b = 1'b0;
            end
            if (dn) begin
                if (done_cnt < 2) done_cyc[done_cnt] = cyc;
                done_cnt++;
            end
            if (done_cnt == ndumps) break;
            if (!b) busy_low++;
            if (pst && (!v || d != pd || l != pl)) unstable++;
            if (mode == 1 && fv_cyc >= 0 && b && addr > beats + 1) occ_bad++;
            if (v && fv_cyc < 0) begin
                fv_cyc  = cyc;
                fv_data = int'(d);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 1) == 1);
                2:       r = (fv_cyc >= 0 && cyc >= fv_cyc + 100);
                default: r = cyc[0];
            endcase
            if (mode == 2 && fv_cyc >= 0 && cyc == fv_cyc + 99) stall_addr = addr;
            if (s) px_s.px_ready = r; else px_b.px_ready = r;
            if (v && r) begin
                if (exp_d.size() == 0) begin
                    bad++;
                end else begin
                    if (d != exp_d[0] || l != exp_l[0]) bad++;
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
                if (fx_cyc < 0) fx_cyc = cyc;
                lx_cyc = cyc;
                beats++;
                if (abort_at > 0 && beats == abort_at) begin
                    hit = 1'b1;
                    break;
                end
            end
            pst = v && !r;
            pd  = d;
            pl  = l;
        end
        if (abort_at <= 0) check("done_seen", done_cnt, ndumps);
    endtask

    int nb_b, nb_s;

    initial begin
        px_b.px_ready = 1'b0;
        px_s.px_ready = 1'b0;
        nb_b = nbeats(LAST_B);
        nb_s = nbeats(LAST_S);
        for (int i = 0; i <= LAST_B; i++) ram[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",  int'(ram_addr_b), 0);
        check("rst_valid", int'(px_b.px_valid), 0);
        check("rst_last",  int'(px_b.px_last), 0);
        check("rst_busy",  int'(busy_b), 0);
        check("rst_done",  int'(done_b), 0);
        reset = 1'b0;

        // Full frame, ready held high: exact latency and throughput.
        run(1'b0, 0, 1, 0);
        check("t1_first_valid_cyc", fv_cyc, t0 + 2);
        check("t1_first_data", fv_data, int'(ram[0]));
        check("t1_beats", beats, nb_b);
        check("t1_bad", bad, 0);
        check("t1_done_cyc", done_cyc[0], t0 + 3 + nb_b);
        check("t1_busy_low", busy_low, 0);

        // Random contents, random back-pressure.
        for (int i = 0; i <= LAST_B; i++) ram[i] = DW'($urandom);
        run(1'b0, 1, 1, 0);
        check("t2_beats", beats, nb_b);
        check("t2_bad", bad, 0);
        check("t2_unstable", unstable, 0);
        check("t2_occupancy", occ_bad, 0);

        // Long stall after the first beat.
        run(1'b1, 2, 1, 0);
        check("t3_stall_addr", stall_addr, 1);
        check("t3_beats", beats, nb_s);
        check("t3_bad", bad, 0);
        check("t3_unstable", unstable, 0);
        check("t3_contiguous", lx_cyc - fx_cyc, nb_s - 1);

        // Ready toggling every cycle.
        run(1'b1, 3, 1, 0);
        check("t4_bad", bad, 0);
        check("t4_rate", lx_cyc - fx_cyc, 2 * (nb_s - 1));

        // Start held high: two back-to-back dumps of a constant image.
        for (int i = 0; i <= LAST_B; i++) ram[i] = 3'b101;
        run(1'b1, 0, 2, 0);
        check("t5_beats", beats, 2 * nb_s);
        check("t5_bad", bad, 0);
        check("t5_busy_low", busy_low, 2);
        check("t5_done_gap", done_cyc[1] - done_cyc[0], nb_s + 5);

        // Reset in the middle of a dump, then restart from address 0.
        for (int i = 0; i <= LAST_B; i++) ram[i] = DW'($urandom);
        run(1'b0, 0, 1, 500);
        check("t6_abort_reached", int'(hit), 1);
        check("t6_bad", bad, 0);
        reset = 1'b1;
        #1;
        check("t6_rst_addr",  int'(ram_addr_b), 0);
        check("t6_rst_valid", int'(px_b.px_valid), 0);
        check("t6_rst_last",  int'(px_b.px_last), 0);
        check("t6_rst_busy",  int'(busy_b), 0);
        check("t6_rst_done",  int'(done_b), 0);
        #2;
        reset = 1'b0;
        px_b.px_ready = 1'b0;
        run(1'b0, 1, 1, 64);
        check("t7_restart_reached", int'(hit), 1);
        check("t7_first_data", fv_data, int'(ram[0]));
        check("t7_bad", bad, 0);
        check("t7_unstable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
